frame_minmax: RTL and testbench
===============================

# frame_minmax

Streaming signed min/max reducer that consumes the signed less-than comparator (`slt`) and sits directly downstream of it in the datapath. It accepts a valid/ready stream of N-bit two's-complement samples. It groups them into frames of L samples, or shorter frames closed by `flush`. For each frame it emits one result (minimum, maximum and sample count) on a registered valid/ready output port. Every ordering decision is made by `slt` instances; the block contains no other magnitude comparison.

## Interface
- `N`, default 32: sample width; signed two's complement.
- `L`, default 4: samples per full frame; must be ≥ 1.
- `CW`, default `$clog2(L+1)`: width of the count field.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: a sample is offered.
- `in_ready`, output, 1: the block can accept a sample.
- `in_data`, input, N: the signed sample.
- `flush`, input, 1: close the current frame early.
- `out_valid`, output, 1: a frame result is held.
- `out_ready`, input, 1: the consumer takes the result.
- `out_min`, output, N: signed minimum of the frame.
- `out_max`, output, N: signed maximum of the frame.
- `out_count`, output, CW: number of samples in the frame, from 1 to L.

## Operation
- A sample is accepted when `in_valid && in_ready`. A result is taken when `out_valid && out_ready`.
- FSM states are `S_IDLE`, `S_ACCUM` and `S_DONE`. The reset state is `S_IDLE`.
- **`S_IDLE`** (`in_ready=1`, `out_valid=0`, count = 0):
  - On an accepted sample: `min = max = in_data`, count = 1.
  - Then go to `S_DONE` if `L == 1` or `flush` is high; otherwise go to `S_ACCUM`.
  - `flush` with no accepted sample is ignored, so no empty frame is produced.
- **`S_ACCUM`** (`in_ready=1`):
  - On an accepted sample, min is replaced by `in_data` if `slt(in_data, min)`.
  - Max is replaced by `in_data` if `slt(max, in_data)`.
  - Count increments on every accepted sample.
  - Go to `S_DONE` when the new count equals L, or when `flush` is high.
  - If `flush` arrives in the same cycle as an accepted sample, that sample is included in the closing frame.
  - `flush` without a sample also goes to `S_DONE`.
- **`S_DONE`** (`in_ready=0`, `out_valid=1`):
  - Outputs hold stable until the result is taken.
  - When the result is taken, go to `S_IDLE`.
  - `flush` and `in_valid` are ignored in this state.
- Ties never update the stored value, because the comparison is strict.
- Comparisons must be correct across the full signed range, including `0x80000000` against `0x7FFFFFFF`.
- `out_min`, `out_max` and `out_count` come directly from registers; they are not driven combinationally.
- Reset asserted at any time, including mid-frame or while holding a result:
  - The FSM returns to `S_IDLE` immediately.
  - The partial frame is discarded.
  - All outputs are forced to their reset values.

## Timing
- Reset values: `out_valid=0`, `out_min=0`, `out_max=0`, `out_count=0`, `in_ready=1`.
- `in_ready` is a decode of FSM state only. It has no combinational path from `out_ready`.
- Latency: `out_valid` rises on the cycle after the closing sample (or closing `flush`) is accepted.
- Throughput with `out_ready` held high: one frame every L+1 cycles, because `S_DONE` occupies one cycle.
- Result values change only on entry to `S_DONE`. They are stable for as long as `out_valid` is high.
- The first sample of the next frame is accepted no earlier than the cycle after the result is taken.

## Structure
- Shared package `frame_minmax_pkg` holds:
  - the `state_t` enum (`S_IDLE`, `S_ACCUM`, `S_DONE`);
  - the default localparams for N and L.
- Sub-modules:
  - Two instances of the existing `slt` module, one for the min path and one for the max path, each with `N` propagated.
  - `slt` depends on `adder_n`. Add both to the Makefile source list.

## Test plan
All scenarios use N=32, L=4.
1. **Full frame:** samples 5, -3, 7, 0 with `out_ready=1` -> one cycle after the 4th accept, `out_valid=1`, `out_min=0xFFFFFFFD`, `out_max=7`, `out_count=4`; `in_ready=0` for that cycle.
2. **Signed extremes:** samples `0x80000000`, `0x7FFFFFFF`, `0xFFFFFFFF`, `0x00000001` -> `out_min=0x80000000`, `out_max=0x7FFFFFFF`.
3. **Flush:**
   - samples 10, 10, then `flush` alone -> `out_min=out_max=10`, `out_count=2`;
   - `flush` in `S_IDLE` -> no `out_valid` in the following 5 cycles;
   - `flush` together with the 2nd sample (10, then -4+flush) -> `out_count=2`, `out_min=-4`, `out_max=10`.
4. **Backpressure:** complete a frame, then hold `out_ready=0` for 5 cycles while `in_valid=1` -> `in_ready=0` throughout, outputs unchanged, no sample consumed. Raise `out_ready` -> the next frame starts with the held sample one cycle later.
5. **Reset mid-frame:** assert `rst_n=0` after 3 samples -> all outputs read 0 asynchronously. After release, the samples 1, 2, 3, 4 yield `out_min=1`, `out_max=4`, `out_count=4`.
6. **Back-to-back frames:** 8 samples with `in_valid` and `out_ready` held high -> exactly two results, 5 cycles apart, with correct per-frame min and max.

Source files
------------

// File: rtl/frame_minmax_pkg.sv
// frame_minmax_pkg
// Shared definitions for the frame min/max reducer: FSM state encoding and
// the default sample width and frame length.

package frame_minmax_pkg;

    localparam int N_DEFAULT = 32;
    localparam int L_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage : frame_minmax_pkg

// File: rtl/adder_n.sv
// adder_n
// N-bit ripple adder with carry in and carry out.
// Ports:
//   a, b  : N-bit addends
//   cin   : carry in
//   sum   : N-bit sum
//   cout  : carry out of the top bit

module adder_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule : adder_n

// File: rtl/slt.sv
// slt
// Signed less-than comparator: lt = 1 when $signed(a) < $signed(b).
// Built on adder_n computing a + ~b + 1.
// Ports:
//   a, b : N-bit two's-complement operands
//   lt   : strict signed less-than flag

module slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    logic [N-1:0] diff;
    logic         carry;
    logic         unused_diff;

    adder_n #(.N(N)) u_sub (
        .a    (a),
        .b    (~b),
        .cin  (1'b1),
        .sum  (diff),
        .cout (carry)
    );

    // The carry out is the unsigned a >= b flag. Folding in both sign bits
    // turns it into the signed order, which is the same as sum_msb ^ overflow
    // but does not need the intermediate carry into the top bit.
    assign lt = a[N-1] ^ ~b[N-1] ^ carry;

    // Only the carry is needed; the difference bits are left unused.
    assign unused_diff = ^diff;

endmodule : slt

// File: rtl/frame_minmax.sv
// frame_minmax
// Streaming signed min/max reducer. Groups a valid/ready stream of signed
// samples into frames of L samples (or shorter, closed by flush) and emits
// one registered result per frame: minimum, maximum and sample count.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake
//   in_data               : signed N-bit sample
//   flush                 : close the current frame early
//   out_valid/out_ready   : result handshake
//   out_min, out_max      : signed frame minimum / maximum (registered)
//   out_count             : samples in the frame, 1..L (registered)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no frame open; next accepted sample starts a frame
// S_ACCUM | frame open, folding samples into the running min/max/count
// S_DONE  | result held on the output port until taken; input stalled

module frame_minmax
    import frame_minmax_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int L  = L_DEFAULT,
    parameter int CW = $clog2(L + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_min,
    output logic [N-1:0]  out_max,
    output logic [CW-1:0] out_count
);

    state_t        state, state_nxt;
    logic [N-1:0]  acc_min, acc_max;
    logic [CW-1:0] acc_count;
    logic [N-1:0]  min_nxt, max_nxt;
    logic [CW-1:0] count_nxt;
    logic          load_out;
    logic          accept, take;
    logic          in_lt_min, max_lt_in;

    // Handshake flags are pure state decodes; no path from out_ready to in_ready.
    assign in_ready  = (state != S_DONE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    slt #(.N(N)) u_slt_min (
        .a  (in_data),
        .b  (acc_min),
        .lt (in_lt_min)
    );

    slt #(.N(N)) u_slt_max (
        .a  (acc_max),
        .b  (in_data),
        .lt (max_lt_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        min_nxt   = acc_min;
        max_nxt   = acc_max;
        count_nxt = acc_count;
        load_out  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    min_nxt   = in_data;
                    max_nxt   = in_data;
                    count_nxt = CW'(1);
                    if (L == 1 || flush) begin
                        state_nxt = S_DONE;
                        load_out  = 1'b1;
                    end else begin
                        state_nxt = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    // Strict compares: ties keep the stored value.
                    if (in_lt_min) min_nxt = in_data;
                    if (max_lt_in) max_nxt = in_data;
                    count_nxt = acc_count + 1'b1;
                end
                if (flush || (accept && count_nxt == CW'(L))) begin
                    state_nxt = S_DONE;
                    load_out  = 1'b1;
                end
            end
            S_DONE: begin
                if (take) begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Running accumulators plus a separate result register, so the port
    // values only move on entry to S_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_min   <= '0;
            acc_max   <= '0;
            acc_count <= '0;
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
        end else begin
            acc_min   <= min_nxt;
            acc_max   <= max_nxt;
            acc_count <= count_nxt;
            if (load_out) begin
                out_min   <= min_nxt;
                out_max   <= max_nxt;
                out_count <= count_nxt;
            end
        end
    end

endmodule : frame_minmax

// File: tb/tb_frame_minmax.sv
// tb_frame_minmax
// Self-checking bench for frame_minmax (N=32, L=4). Inputs change and outputs
// are sampled on the falling edge; expected frame results come from a
// queue of accepted samples reduced with plain signed comparisons.

module tb_frame_minmax;

    localparam int N  = 32;
    localparam int L  = 4;
    localparam int CW = $clog2(L + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_min, out_max;
    logic [CW-1:0] out_count;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] frame_q[$];
    logic [N-1:0] exp_min, exp_max;
    int           exp_cnt;

    frame_minmax #(.N(N), .L(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    // Reference: reduce the accepted samples of the current frame.
    task automatic compute_model();
        exp_cnt = frame_q.size();
        exp_min = frame_q[0];
        exp_max = frame_q[0];
        foreach (frame_q[i]) begin
            if ($signed(frame_q[i]) < $signed(exp_min)) exp_min = frame_q[i];
            if ($signed(frame_q[i]) > $signed(exp_max)) exp_max = frame_q[i];
        end
    endtask

    // Present one cycle of input (called just after a falling edge); a sample
    // is recorded in the model when offered, callers only offer while in_ready.
    task automatic push(input logic [N-1:0] d, input logic v, input logic f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        if (v) frame_q.push_back(d);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    function automatic logic [N-1:0] rand_sample();
        logic [N-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = 32'h8000_0000;
            1:       v = 32'h7FFF_FFFF;
            2:       v = N'($urandom_range(0, 3)) - N'(1);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        n_vec++; if (out_min !== '0) begin n_err++; $display("FAIL reset_out_min got=%h want=0", out_min); end
        n_vec++; if (out_max !== '0) begin n_err++; $display("FAIL reset_out_max got=%h want=0", out_max); end
        n_vec++; if (out_count !== '0) begin n_err++; $display("FAIL reset_out_count got=%0d want=0", out_count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        out_ready = 1'b1;
        frame_q.delete();
        push(32'd5, 1, 0);
        push(-32'sd3, 1, 0);
        push(32'd7, 1, 0);
        push(32'd0, 1, 0);
        compute_model();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_out_valid got=%0b want=1", out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got=%0b want=0", in_ready); end
        n_vec++; if (out_min !== exp_min) begin n_err++; $display("FAIL full_min got=%h want=%h", out_min, exp_min); end
        n_vec++; if (out_max !== exp_max) begin n_err++; $display("FAIL full_max got=%h want=%h", out_max, exp_max); end
        n_vec++; if (out_count !== CW'(exp_cnt)) begin n_err++; $display("FAIL full_count got=%0d want=%0d", out_count, exp_cnt); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_taken got=%0b want=0", out_valid); end
    endtask

    task automatic test_extremes();
        out_ready = 1'b1;
        frame_q.delete();
        push(32'h8000_0000, 1, 0);
        push(32'h7FFF_FFFF, 1, 0);
        push(32'hFFFF_FFFF, 1, 0);
        push(32'h0000_0001, 1, 0);
        compute_model();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ext_out_valid got=%0b want=1", out_valid); end
        n_vec++; if (out_min !== exp_min) begin n_err++; $display("FAIL ext_min got=%h want=%h", out_min, exp_min); end
        n_vec++; if (out_max !== exp_max) begin n_err++; $display("FAIL ext_max got=%h want=%h", out_max, exp_max); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        // Two samples then a bare flush.
        frame_q.delete();
        push(32'd10, 1, 0);
        push(32'd10, 1, 0);
        push('0, 0, 1);
        compute_model();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_a_valid got=%0b want=1", out_valid); end
        n_vec++; if (out_count !== CW'(exp_cnt)) begin n_err++; $display("FAIL flush_a_count got=%0d want=%0d", out_count, exp_cnt); end
        n_vec++; if (out_min !== exp_min) begin n_err++; $display("FAIL flush_a_min got=%h want=%h", out_min, exp_min); end
        n_vec++; if (out_max !== exp_max) begin n_err++; $display("FAIL flush_a_max got=%h want=%h", out_max, exp_max); end
        @(negedge clk);
        // Flush with no open frame produces nothing.
        push('0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle_valid cycle=%0d got=%0b want=0", i, out_valid); end
            @(negedge clk);
        end
        // Flush riding on the second sample includes that sample.
        frame_q.delete();
        push(32'd10, 1, 0);
        push(-32'sd4, 1, 1);
        compute_model();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_c_valid got=%0b want=1", out_valid); end
        n_vec++; if (out_count !== CW'(exp_cnt)) begin n_err++; $display("FAIL flush_c_count got=%0d want=%0d", out_count, exp_cnt); end
        n_vec++; if (out_min !== exp_min) begin n_err++; $display("FAIL flush_c_min got=%h want=%h", out_min, exp_min); end
        n_vec++; if (out_max !== exp_max) begin n_err++; $display("FAIL flush_c_max got=%h want=%h", out_max, exp_max); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [N-1:0]  held;
        logic [N-1:0]  snap_min, snap_max;
        logic [CW-1:0] snap_cnt;
        out_ready = 1'b0;
        frame_q.delete();
        for (int i = 0; i < 4; i++) push(rand_sample(), 1, 0);
        compute_model();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got=%0b want=1", out_valid); end
        n_vec++; if (out_min !== exp_min) begin n_err++; $display("FAIL bp_min got=%h want=%h", out_min, exp_min); end
        n_vec++; if (out_max !== exp_max) begin n_err++; $display("FAIL bp_max got=%h want=%h", out_max, exp_max); end
        snap_min = exp_min;
        snap_max = exp_max;
        snap_cnt = CW'(exp_cnt);
        held     = $urandom;
        in_valid = 1'b1;
        in_data  = held;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cycle=%0d got=%0b want=0", i, in_ready); end
            n_vec++; if (out_valid !== 1'b1 || out_min !== snap_min || out_max !== snap_max || out_count !== snap_cnt) begin
                n_err++;
                $display("FAIL bp_hold cycle=%0d got=%0b/%h/%h/%0d want=1/%h/%h/%0d",
                         i, out_valid, out_min, out_max, out_count, snap_min, snap_max, snap_cnt);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_taken got=%0b want=0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_reopen got=%0b want=1", in_ready); end
        // The held sample is accepted on this edge and starts the next frame.
        frame_q.delete();
        frame_q.push_back(held);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) push(rand_sample(), 1, 0);
        compute_model();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid got=%0b want=1", out_valid); end
        n_vec++; if (out_count !== CW'(exp_cnt)) begin n_err++; $display("FAIL bp_next_count got=%0d want=%0d", out_count, exp_cnt); end
        n_vec++; if (out_min !== exp_min) begin n_err++; $display("FAIL bp_next_min got=%h want=%h", out_min, exp_min); end
        n_vec++; if (out_max !== exp_max) begin n_err++; $display("FAIL bp_next_max got=%h want=%h", out_max, exp_max); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        frame_q.delete();
        for (int i = 0; i < 3; i++) push(rand_sample(), 1, 0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_min !== '0 || out_max !== '0 || out_count !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_async got=%0b/%h/%h/%0d/%0b want=0/0/0/0/1",
                     out_valid, out_min, out_max, out_count, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame_q.delete();
        push(32'd1, 1, 0);
        push(32'd2, 1, 0);
        push(32'd3, 1, 0);
        push(32'd4, 1, 0);
        compute_model();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_post_valid got=%0b want=1", out_valid); end
        n_vec++; if (out_count !== CW'(exp_cnt)) begin n_err++; $display("FAIL rst_post_count got=%0d want=%0d", out_count, exp_cnt); end
        n_vec++; if (out_min !== exp_min) begin n_err++; $display("FAIL rst_post_min got=%h want=%h", out_min, exp_min); end
        n_vec++; if (out_max !== exp_max) begin n_err++; $display("FAIL rst_post_max got=%h want=%h", out_max, exp_max); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] samples[8];
        logic         acc;
        int idx = 0;
        int nres = 0;
        int res_cyc[2];
        for (int i = 0; i < 8; i++) samples[i] = rand_sample();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = samples[0];
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (out_valid) begin
                if (nres < 2) begin
                    frame_q.delete();
                    for (int k = 0; k < 4; k++) frame_q.push_back(samples[nres*4 + k]);
                    compute_model();
                    n_vec++; if (out_min !== exp_min || out_max !== exp_max || out_count !== CW'(exp_cnt)) begin
                        n_err++;
                        $display("FAIL b2b_frame%0d got=%h/%h/%0d want=%h/%h/%0d",
                                 nres, out_min, out_max, out_count, exp_min, exp_max, exp_cnt);
                    end
                    res_cyc[nres] = cyc;
                end
                nres++;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx == 8) in_valid = 1'b0;
                else          in_data  = samples[idx];
            end
        end
        in_valid = 1'b0;
        n_vec++; if (nres != 2) begin n_err++; $display("FAIL b2b_result_count got=%0d want=2", nres); end
        if (nres >= 2) begin
            n_vec++; if (res_cyc[1] - res_cyc[0] != L + 1) begin
                n_err++;
                $display("FAIL b2b_spacing got=%0d want=%0d", res_cyc[1] - res_cyc[0], L + 1);
            end
        end
    endtask

    task automatic test_random_frames();
        for (int fr = 0; fr < 40; fr++) begin
            int len   = $urandom_range(1, L);
            bit bare  = $urandom_range(0, 1) == 1;
            int stall = $urandom_range(0, 3);
            out_ready = 1'b0;
            frame_q.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) push('0, 0, 0);
                if (i == len - 1 && len < L && !bare) push(rand_sample(), 1, 1);
                else                                  push(rand_sample(), 1, 0);
            end
            if (len < L && bare) push('0, 0, 1);
            compute_model();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rnd%0d_valid got=%0b want=1", fr, out_valid); end
            n_vec++; if (out_count !== CW'(exp_cnt)) begin n_err++; $display("FAIL rnd%0d_count got=%0d want=%0d", fr, out_count, exp_cnt); end
            n_vec++; if (out_min !== exp_min) begin n_err++; $display("FAIL rnd%0d_min got=%h want=%h", fr, out_min, exp_min); end
            n_vec++; if (out_max !== exp_max) begin n_err++; $display("FAIL rnd%0d_max got=%h want=%h", fr, out_max, exp_max); end
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                n_vec++; if (in_ready !== 1'b0 || out_min !== exp_min || out_max !== exp_max) begin
                    n_err++;
                    $display("FAIL rnd%0d_stall got=%0b/%h/%h want=0/%h/%h", fr, in_ready, out_min, out_max, exp_min, exp_max);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd%0d_taken got=%0b want=0", fr, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_extremes();
        test_flush();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_frame_minmax
